// File: rtl/accum_bank_buffer.sv
// Double-buffered, skew-addressed accumulator sitting between the systolic
// array drain and the unified-buffer writeback path.
module accum_bank_buffer #(
  parameter int COLS     = 8,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int SATURATE = 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         wr_en_i,
  input  logic                         wr_acc_i,
  input  logic [AW-1:0]                wr_addr_i,
  input  logic [COLS-1:0]              wr_mask_i,
  input  logic [COLS-1:0][DATA_W-1:0]  wr_data_i,
  input  logic                         rd_en_i,
  input  logic                         rd_clear_i,
  input  logic [AW-1:0]                rd_addr_i,
  input  logic                         swap_i,
  output logic [COLS-1:0][DATA_W-1:0]  rd_data_o,
  output logic                         rd_valid_o,
  output logic                         wr_bank_o,
  output logic                         ovf_o
);

  localparam logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  // Strobe semantics: wr_en_i, rd_en_i and swap_i are single-cycle commands
  // sampled at the rising edge; there is no back-pressure, every command
  // issued is accepted in that cycle.
  logic [DATA_W-1:0] mem_q [2][COLS][DEPTH];

  logic                        wr_bank_q, wr_bank_d;
  logic                        rd_bank;
  logic                        ovf_q, ovf_d;
  logic                        rd_valid_q, rd_valid_d;
  logic [COLS-1:0][DATA_W-1:0] rd_data_q, rd_data_d;

  logic [AW-1:0]     wr_row  [COLS];
  logic [AW-1:0]     rd_row  [COLS];
  logic [DATA_W-1:0] old_val [COLS];
  logic [DATA_W:0]   sum     [COLS];
  logic [DATA_W-1:0] new_val [COLS];
  logic [COLS-1:0]   sum_ovf;
  logic [COLS-1:0]   col_ovf;

  assign rd_bank = ~wr_bank_q;

  always_comb begin
    for (int j = 0; j < COLS; j++) begin
      // Column j trails the base row by j so a diagonal wavefront lands in one row.
      wr_row[j]  = wr_addr_i - AW'(j);
      rd_row[j]  = rd_addr_i - AW'(j);
      old_val[j] = mem_q[wr_bank_q][j][wr_row[j]];
      sum[j]     = {old_val[j][DATA_W-1], old_val[j]} +
                   {wr_data_i[j][DATA_W-1], wr_data_i[j]};
      sum_ovf[j] = sum[j][DATA_W] ^ sum[j][DATA_W-1];

      new_val[j] = sum[j][DATA_W-1:0];
      if (!wr_acc_i) begin
        new_val[j] = wr_data_i[j];
      end else if ((SATURATE != 0) && sum_ovf[j]) begin
        new_val[j] = sum[j][DATA_W] ? MIN_VAL : MAX_VAL;
      end

      col_ovf[j]   = wr_en_i & wr_mask_i[j] & wr_acc_i & sum_ovf[j];
      rd_data_d[j] = rd_en_i ? mem_q[rd_bank][j][rd_row[j]] : '0;
    end
  end

  always_comb begin
    wr_bank_d  = wr_bank_q ^ swap_i;
    // An overflow coinciding with a swap belongs to the bank leaving write duty.
    ovf_d      = swap_i ? 1'b0 : (ovf_q | (|col_ovf));
    rd_valid_d = rd_en_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_bank_q  <= 1'b0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Writes and clears always target different banks, so they never collide.
  always_ff @(posedge clk_i) begin
    for (int j = 0; j < COLS; j++) begin
      if (wr_en_i && wr_mask_i[j]) begin
        mem_q[wr_bank_q][j][wr_row[j]] <= new_val[j];
      end
      if (rd_en_i && rd_clear_i) begin
        mem_q[rd_bank][j][rd_row[j]] <= '0;
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign wr_bank_o  = wr_bank_q;
  assign ovf_o      = ovf_q;

endmodule
